mont_mul_r2: RTL and testbench
==============================

# mont_mul_r2

Bit-serial radix-2 Montgomery multiplier computing `a·b·R⁻¹ mod n` with `R = 2^WIDTH`. It is the responder side of the modular-exponentiation engine's multiply handshake. It accepts a level `start` plus operands, iterates one multiplier bit per clock, and returns `result` with a one-cycle `done` pulse. Its port set matches what the exponentiation controller instantiates, so it drops in without glue.

## Interface
- `WIDTH`, default 1024: operand/modulus width in bits; `R = 2^WIDTH`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: level request; sampled only in IDLE.
- `a` input, WIDTH bits: multiplicand, scanned LSB first.
- `b` input, WIDTH bits: multiplier operand.
- `n` input, WIDTH bits: modulus; must be odd.
- `n_prime` input, WIDTH bits: accepted for interface compatibility and unused, because radix-2 needs only `n0' = 1` for odd `n`.
- `result` output, WIDTH bits: registered product; holds until the next completion.
- `done` output, 1 bit: registered completion pulse, exactly one cycle wide.

## Operation
- States: IDLE, ITER, FIN (FIN exists only with `MONT_FINAL_SUB_EN`).
- IDLE with `start=1` at an edge:
  - latch `a`, `b`, `n` into internal registers;
  - clear accumulator `T` (WIDTH+2 bits) and bit counter `i` (clog2(WIDTH) bits);
  - go to ITER.
- IDLE with `start=0`: stay in IDLE.
- ITER, one edge per bit:
  - `T1 = T + (a_reg[i] ? b_reg : 0)`;
  - if `T1[0]`, `T1 += n_reg`;
  - `T <= T1 >> 1`;
  - `i <= i+1`.
- On the edge where `i == WIDTH-1`:
  - go to FIN with `MONT_FINAL_SUB_EN`;
  - without it, write `result <= T_next[WIDTH-1:0]`, set `done <= 1`, and go to IDLE.
- FIN (one edge): `result <= (T >= n_reg) ? T - n_reg : T`, truncated to WIDTH; `done <= 1`; go to IDLE.
- `done` clears on the edge after it is set.
- `start` is ignored outside IDLE. Operand inputs may change freely after the sampling edge.
- Back-to-back operation: if `start` is still high in the IDLE cycle after `done`, a new operation begins on that edge with the operands presented then. An initiator that updates `a`/`b` on the `done` edge is therefore served correctly.
- Width rules, with final subtraction: requires `a, b < n`; invariant `T < 2n`; `result < n`.
- Width rules, without final subtraction: requires `4n < R` and `a, b < 2n`; invariant `T < 2n`; `result < 2n` and `result ≡ a·b·R⁻¹ (mod n)`.
- Even `n`: `result` is unspecified, but `done` still fires at the nominal latency. No hang is permitted.
- Reset values: state IDLE, `done=0`, `result=0`, `T=0`, `i=0`.
- Reset asserted mid-operation aborts immediately. No `done` is produced for the aborted operation.

## Timing
- Label the IDLE edge that samples `start=1` as edge 0.
- With `MONT_FINAL_SUB_EN`: ITER occupies edges 1..WIDTH; FIN is edge WIDTH+1. `done` and the new `result` are visible after edge WIDTH+1, i.e. latency WIDTH+1 cycles.
- Without it: `done` and `result` are visible after edge WIDTH, i.e. latency WIDTH cycles.
- Minimum spacing between consecutive start-sampling edges: latency + 1 cycles (the return through IDLE).
- `result` changes only on the edge that sets `done`.

## Configuration
- Macro: `MONT_FINAL_SUB_EN`.
- Defined: FIN state and conditional subtraction are compiled in, giving a fully reduced `result < n` at latency WIDTH+1.
- Undefined: no FIN state and no WIDTH+2-bit comparator/subtractor; `result < 2n` (lazy reduction) at latency WIDTH. Callers must keep `4n < R`.

## Test plan
All scenarios use WIDTH=8 and n=13, so R mod n = 9 and R⁻¹ mod n = 3.
- Basic product: `a=5, b=7`, pulse `start` → `done` after 9 cycles (8 without the macro); `result=1`. `done` is high for exactly one cycle.
- Zero and identity: `a=0, b=12` → `result=0`. `a=1, b=9` → `result=1`. `a=9, b=9` → `result=9`.
- Back-to-back: hold `start=1`; first operands `a=5, b=7`; change to `a=9, b=9` on the `done` edge → second `done` after exactly latency+1 cycles with `result=9`.
- Start ignored while busy: toggle `start` and change `a`/`b` during ITER → first result is unaffected (`1`), and no extra operation is started once `start` is held low.
- Reset mid-operation: assert `rst=0` at cycle 4 of ITER → `done=0`, `result=0`, state IDLE immediately; after release, a new `a=5, b=7` request completes normally with `result=1`.
- Random sweep: random `a, b < 13`, compared against the reference `a·b·3 mod 13` → exact match with the macro; congruent mod 13 and `< 26` without it.

Source files
------------

// File: rtl/mont_mul_r2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^WIDTH; define MONT_FINAL_SUB_EN for full reduction.
// Latency: WIDTH cycles from the start-sampling edge (WIDTH+1 with MONT_FINAL_SUB_EN); done is a one-cycle pulse.
// Backpressure: none; start is a level request sampled only in IDLE and ignored while busy.
module mont_mul_r2 #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] n_prime,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MONT_FINAL_SUB_EN
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ITER} state_t;
`endif

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, n_reg;
    logic [WIDTH+1:0] t_q, t_sum, t_odd, t_nxt;
    logic [CW-1:0]    i_q;
    logic             load, step, res_wr;
    logic [WIDTH-1:0] res_nxt;

    // Odd n means n0' = 1, so the precomputed n' is never needed.
    logic unused_n_prime;
    assign unused_n_prime = ^n_prime;

    always_comb begin
        t_sum = t_q + (a_reg[i_q] ? {2'b00, b_reg} : '0);
        t_odd = t_sum + (t_sum[0] ? {2'b00, n_reg} : '0);
        t_nxt = t_odd >> 1;
    end

`ifdef MONT_FINAL_SUB_EN
    logic [WIDTH+1:0] t_sub;
    always_comb begin
        t_sub   = t_q - {2'b00, n_reg};
        res_nxt = (t_q >= {2'b00, n_reg}) ? t_sub[WIDTH-1:0] : t_q[WIDTH-1:0];
    end
`else
    assign res_nxt = t_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        step      = 1'b0;
        res_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                step = 1'b1;
                if (i_q == LAST) begin
`ifdef MONT_FINAL_SUB_EN
                    state_nxt = FIN;
`else
                    res_wr    = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef MONT_FINAL_SUB_EN
            FIN: begin
                res_wr    = 1'b1;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            n_reg  <= '0;
            t_q    <= '0;
            i_q    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_reg <= a;
                b_reg <= b;
                n_reg <= n;
                t_q   <= '0;
                i_q   <= '0;
            end else if (step) begin
                t_q <= t_nxt;
                i_q <= i_q + CW'(1);
            end
            // result only moves on the edge that raises done
            if (res_wr) begin
                result <= res_nxt;
                done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mont_mul_r2.sv
// Bench for mont_mul_r2 at WIDTH=8, n=13: REDC-formula reference model plus directed scenarios.
module tb_mont_mul_r2;
    localparam int W = 8;
    localparam int R = 256;
    localparam int N = 13;
`ifdef MONT_FINAL_SUB_EN
    localparam int LAT = W + 1;
    localparam int BOUND = N;
`else
    localparam int LAT = W;
    localparam int BOUND = 2 * N;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] n = 8'd13;
    logic [W-1:0] n_prime = 8'd59;
    logic [W-1:0] result;
    logic         done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mont_mul_r2 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .n(n),
        .n_prime(n_prime), .result(result), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ninv();
        int x = 0;
        for (int k = 1; k < R; k++)
            if (((N * k) % R) == 1) x = k;
        return x;
    endfunction

    // T = (ab + q*n)/R where q = -ab*n^-1 mod R makes the numerator divisible by R
    function automatic int ref_mont(input int ra, input int rb);
        int ab, q, t;
        ab = ra * rb;
        q  = ((R - (ab % R)) * ninv()) % R;
        t  = (ab + q * N) / R;
`ifdef MONT_FINAL_SUB_EN
        if (t >= N) t = t - N;
`endif
        return t;
    endfunction

    int           m_busy = 0;
    int           m_a = 0, m_b = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    m_res  = W'(ref_mont(m_a, m_b));
                end
            end else if (start) begin
                m_a    = int'(a);
                m_b    = int'(b);
                m_busy = LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("done_cycle", int'(done), int'(m_done));
            check("result_cycle", int'(result), int'(m_res));
        end
    end

    task automatic wait_done(output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", cyc);
        end
    endtask

    task automatic run_op(input int ta, input int tb_v, input int expv);
        int c;
        @(negedge clk);
        a = W'(ta);
        b = W'(tb_v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(c);
        check("latency", c, LAT);
        check("result", int'(result), expv);
        check("congruence", int'(result) % N, (ta * tb_v * 3) % N);
        check("bound", int'(result < BOUND), 1);
        @(posedge clk);
        #1 check("done_width", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cnt;
        int ra, rb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1;
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        @(negedge clk) rst = 1'b1;

        check("model_ninv", ninv(), 197);
        check("model_5_7", ref_mont(5, 7), 1);
        check("model_0_12", ref_mont(0, 12), 0);
        check("model_1_9", ref_mont(1, 9), 1);
        check("model_9_9", ref_mont(9, 9), 9);

        run_op(5, 7, 1);
        run_op(0, 12, 0);
        run_op(1, 9, 1);
        run_op(9, 9, 9);

        // back-to-back with start held high, operands swapped on the done edge
        @(negedge clk);
        a = 8'd5;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk);
        wait_done(c);
        check("b2b_first_lat", c, LAT);
        check("b2b_first_res", int'(result), 1);
        a = 8'd9;
        b = 8'd9;
        wait_done(c);
        start = 1'b0;
        check("b2b_second_lat", c, LAT + 1);
        check("b2b_second_res", int'(result), 9);
        repeat (2) @(posedge clk);

        // start toggles and operand changes while busy must be ignored
        @(negedge clk);
        a = 8'd5;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 begin start = 1'b1; a = 8'd9; b = 8'd3; end
        @(posedge clk);
        #1 begin start = 1'b0; a = 8'd2; end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(c);
        check("busy_lat", c, LAT - 4);
        check("busy_res", int'(result), 1);
        cnt = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk);
            #1 if (done) cnt++;
        end
        check("busy_no_extra_op", cnt, 0);

        // reset in the fourth ITER cycle aborts at once
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        @(negedge clk) rst = 1'b1;
        run_op(5, 7, 1);

        for (int k = 0; k < 20; k++) begin
            ra = int'($urandom_range(0, N - 1));
            rb = int'($urandom_range(0, N - 1));
            run_op(ra, rb, ref_mont(ra, rb));
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
